// File: rtl/periph_timer_pkg.sv
// Shared register map for the periph_timer peripheral: word offsets, CTRL
// and STATUS bit positions, and a helper that assembles the CTRL read value.
package periph_timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_RELOAD = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_ONESHOT   = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_MSB = 15;

    localparam int STATUS_FLAG = 0;

    // Bits [7:3] are reserved and always read back as zero.
    function automatic logic [15:0] packCtrl(input logic en, input logic oneshot,
                                             input logic irqEn, input logic [7:0] presc);
        logic [15:0] v;
        v = '0;
        v[CTRL_EN] = en;
        v[CTRL_ONESHOT] = oneshot;
        v[CTRL_IRQ_EN] = irqEn;
        v[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc;
        return v;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: while enabled, pulses tick_o for one clock every
// presc_i+1 clocks; clear_i restarts the period.
module timer_prescaler (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [7:0] presc_i,
    output logic       tick_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // The >= keeps the period sane if PRESC is lowered below the running count.
    assign tick_o = enable_i & ~clear_i & (cnt_q >= presc_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i) begin
            cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/periph_timer.sv
// Bus-mapped periodic/one-shot timer with a reload compare, sticky FLAG
// and a registered level interrupt request.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0420
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data,
    output logic [15:0] o_data,
    output logic        o_irq
);

    logic        en_q, en_d;
    logic        oneshot_q, oneshot_d;
    logic        irqEn_q, irqEn_d;
    logic [7:0]  presc_q, presc_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic [15:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic [15:0] offset;
    logic [1:0]  regSel;
    logic        hit;
    logic        ctrlWr, reloadWr, countWr, statusWr;
    logic        enRise, prescClear, tick, flagSet;
    logic [15:0] readMux;

    assign offset   = i_addr - BASE_ADDR;
    assign hit      = offset < 16'd4;
    assign regSel   = offset[1:0];
    assign ctrlWr   = i_we & hit & (regSel == OFF_CTRL);
    assign reloadWr = i_we & hit & (regSel == OFF_RELOAD);
    assign countWr  = i_we & hit & (regSel == OFF_COUNT);
    assign statusWr = i_we & hit & (regSel == OFF_STATUS);

    assign enRise     = ctrlWr & i_data[CTRL_EN] & ~en_q;
    assign prescClear = countWr | enRise;
    // tick is already suppressed by a COUNT write, so that tick can never set FLAG.
    assign flagSet    = tick & (count_q == reload_q);

    timer_prescaler u_prescaler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .enable_i (en_q),
        .clear_i  (prescClear),
        .presc_i  (presc_q),
        .tick_o   (tick)
    );

    always_comb begin
        readMux = '0;
        case (regSel)
            OFF_CTRL:   readMux = packCtrl(en_q, oneshot_q, irqEn_q, presc_q);
            OFF_RELOAD: readMux = reload_q;
            OFF_COUNT:  readMux = count_q;
            OFF_STATUS: readMux[STATUS_FLAG] = flag_q;
            default:    readMux = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irqEn_d   = irqEn_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        count_d   = count_q;
        flag_d    = flag_q;
        rdata_d   = rdata_q;
        irq_d     = flag_q & irqEn_q;

        if (ctrlWr) begin
            en_d      = i_data[CTRL_EN];
            oneshot_d = i_data[CTRL_ONESHOT];
            irqEn_d   = i_data[CTRL_IRQ_EN];
            presc_d   = i_data[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end
        if (flagSet & oneshot_q) begin
            en_d = 1'b0;
        end
        if (reloadWr) begin
            reload_d = i_data;
        end
        if (countWr) begin
            count_d = i_data;
        end else if (tick) begin
            count_d = flagSet ? 16'd0 : count_q + 16'd1;
        end
        // A FLAG set event beats a same-cycle write-1-to-clear.
        if (flagSet) begin
            flag_d = 1'b1;
        end else if (statusWr & i_data[STATUS_FLAG]) begin
            flag_d = 1'b0;
        end
        if (!hit) begin
            rdata_d = '0;
        end else if (!i_we) begin
            rdata_d = readMux;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irqEn_q   <= 1'b0;
            presc_q   <= 8'd0;
            reload_q  <= 16'd0;
            count_q   <= 16'd0;
            flag_q    <= 1'b0;
            rdata_q   <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irqEn_q   <= irqEn_d;
            presc_q   <= presc_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            flag_q    <= flag_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign o_data = rdata_q;
    assign o_irq  = irq_q;

endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0420, meaning the first of four consecutive word addresses occupied by the block.
REQ-002 SHALL have port i_clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-low reset, sampled on i_clk.
REQ-004 SHALL have port i_we, input, 1, bus write strobe; low means read.
REQ-005 SHALL have port i_addr, input, 16, bus word address.
REQ-006 SHALL have port i_data, input, 16, bus write data.
REQ-007 SHALL have port o_data, output, 16, registered bus read data.
REQ-008 SHALL have port o_irq, output, 1, registered level interrupt request; drives one i_lines bit of the interrupt controller.

Function
REQ-009 SHALL decode registers: CTRL at BASE_ADDR, RELOAD at BASE_ADDR+1, COUNT at BASE_ADDR+2, STATUS at BASE_ADDR+3.
REQ-010 SHALL define CTRL bits: [0] EN, [1] ONESHOT, [2] IRQ_EN, [7:3] reads 0 and ignores writes, [15:8] PRESC.
REQ-011 SHALL define STATUS bit [0] as FLAG; STATUS bits [15:1] read 0.
REQ-012 SHALL register o_data one cycle after a read (i_we low) to the selected register's value.
REQ-013 SHALL drive o_data to 0 one cycle after any access whose address is outside the four registers.
REQ-014 SHALL leave o_data unchanged for a write cycle to a decoded address.
REQ-015 SHALL return, for a COUNT read, the count value held before that cycle's update.
REQ-016 SHALL, while EN=1, run an 8-bit prescaler that produces one tick every PRESC+1 clocks; PRESC=0 means a tick every clock.
REQ-017 SHALL hold the prescaler and count while EN=0.
REQ-018 SHALL clear the prescaler when EN is written from 0 to 1, so the first tick occurs PRESC+1 clocks after the write.
REQ-019 SHALL, on a tick with COUNT != RELOAD, increment COUNT modulo 2^16.
REQ-020 SHALL, on a tick with COUNT == RELOAD, load COUNT with 0 and set FLAG.
REQ-021 SHALL wrap COUNT from 16'hFFFF to 0 without setting FLAG unless RELOAD == 16'hFFFF, which covers the case where RELOAD is written below the current COUNT.
REQ-022 SHALL, with RELOAD=0, set FLAG on every tick.
REQ-023 SHALL, when ONESHOT=1, clear EN on the same edge that sets FLAG.
REQ-024 SHALL clear FLAG on a write to STATUS with i_data[0]=1; writes with i_data[0]=0 have no effect.
REQ-025 SHALL give a FLAG set event priority over a same-cycle write-1-to-clear of STATUS.
REQ-026 SHALL, on a COUNT write, load COUNT with i_data and clear the prescaler; the write wins over a same-cycle tick, and no FLAG is set from that tick.
REQ-027 SHALL make a RELOAD write take effect for comparisons from the next cycle.
REQ-028 SHALL register o_irq each cycle as (FLAG & IRQ_EN) using pre-edge values, giving one cycle of latency from FLAG to o_irq.
REQ-029 SHALL keep o_irq high until FLAG is cleared or IRQ_EN is written to 0.

Reset
REQ-030 SHALL, while i_rst=0 at a clock edge, clear CTRL, RELOAD, COUNT, FLAG, the prescaler, o_data and o_irq to 0.
REQ-031 SHALL ignore bus accesses during reset; a reset mid-count abandons the count and any pending FLAG.

Structure
REQ-032 SHALL take register offsets (0..3), CTRL bit positions (EN=0, ONESHOT=1, IRQ_EN=2, PRESC=15:8) and the STATUS FLAG position from a shared peripheral package.
REQ-033 SHALL place the prescaler in a sub-module named timer_prescaler, with inputs enable, clear and PRESC, and a one-clock tick output.

Verification
REQ-034 Scenario "periodic": PRESC=0, RELOAD=3, EN=1, IRQ_EN=1 -> FLAG set every 4 clocks, o_irq high 1 clock after the first FLAG.
REQ-035 Scenario "prescaled": PRESC=1, RELOAD=2 -> FLAG set after 6 clocks; a COUNT read mid-run returns 0,1,2 in sequence.
REQ-036 Scenario "oneshot": ONESHOT=1, RELOAD=5, PRESC=0 -> one FLAG, CTRL reads EN=0 afterwards, and COUNT stays 0.
REQ-037 Scenario "clear collision": write STATUS=1 on the exact cycle FLAG sets -> FLAG reads 1 and o_irq stays high; a second STATUS=1 write drops o_irq within 2 cycles.
REQ-038 Scenario "RELOAD below count": COUNT=10, RELOAD written to 4 -> COUNT counts to 16'hFFFF, wraps to 0 with no FLAG, then FLAG is set at 4.
REQ-039 Scenario "reset and decode": assert i_rst=0 mid-run -> all registers and o_irq read 0; a read at BASE_ADDR+4 returns o_data=0.
